// File: rtl/multi_ch_counter_pkg.sv
// multi_ch_counter_pkg
// Shared definitions for the multi-channel counter: parameter bounds,
// per-channel mode encodings, channel state encodings and a helper that
// folds the reserved mode code onto wrap.
package multi_ch_counter_pkg;

   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 16;
   localparam int WIDTH_MIN  = 2;
   localparam int WIDTH_MAX  = 32;
   localparam int PRESCALE_W = 8;

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SATURATE = 2'b01,
      MODE_ONE_SHOT = 2'b10,
      MODE_RESERVED = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } chan_state_e;

   // The reserved code behaves exactly like wrap.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      m = mode_e'(raw);
      if (m == MODE_RESERVED) m = MODE_WRAP;
      return m;
   endfunction

endpackage

// File: rtl/multi_ch_counter_chan.sv
// counter_chan
// One counter channel with IDLE/RUN/DONE control, programmable step,
// terminal value and reload value, registered terminal-count pulse and a
// sticky interrupt status bit.
// Ports:
//   clk, sreset_n            clock, synchronous active-low reset
//   tick                     count qualifier (clken, optionally prescaled)
//   start, stop, clear       control strobes, priority clear > stop > start
//   mode[1:0]                00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   step, limit, clear_value increment, terminal value, reload value
//   irq_clr                  clears irq_status (a simultaneous set wins)
//   count_value, running     counter value, high while in RUN
//   tc_pulse, irq_status     one-cycle terminal pulse, sticky status
module counter_chan
   import multi_ch_counter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             sreset_n,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] clear_value,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] count_value,
   output logic             running,
   output logic             tc_pulse,
   output logic             irq_status
);

   chan_state_e      state, state_next;
   logic [WIDTH-1:0] count_q, count_next;
   logic             tc_next;
   mode_e            mode_sel;

   // State, counter, terminal pulse and sticky status registers.
   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         state      <= ST_IDLE;
         count_q    <= '0;
         tc_pulse   <= 1'b0;
         irq_status <= 1'b0;
      end else begin
         state      <= state_next;
         count_q    <= count_next;
         tc_pulse   <= tc_next;
         irq_status <= tc_pulse | (irq_status & ~irq_clr);
      end
   end

   // Next state and count. Strobes act on every edge regardless of tick;
   // start inside RUN is ignored so counting carries on that cycle.
   // A limit that is stepped over is not a terminal event: the sum simply
   // wraps modulo 2^WIDTH.
   always_comb begin
      state_next = state;
      count_next = count_q;
      tc_next    = 1'b0;
      mode_sel   = decode_mode(mode);
      if (clear) begin
         count_next = clear_value;
         if (state == ST_DONE) state_next = ST_IDLE;
      end else if (stop) begin
         if (state == ST_RUN) state_next = ST_IDLE;
      end else if (start && state != ST_RUN) begin
         if (state == ST_DONE) count_next = clear_value;
         state_next = ST_RUN;
      end else if (state == ST_RUN && tick) begin
         if (count_q == limit) begin
            tc_next = 1'b1;
            case (mode_sel)
               MODE_SATURATE: state_next = ST_DONE;
               MODE_ONE_SHOT: begin
                  count_next = clear_value;
                  state_next = ST_IDLE;
               end
               default: count_next = clear_value;
            endcase
         end else begin
            count_next = count_q + step;
         end
      end
   end

   assign count_value = count_q;
   assign running     = (state == ST_RUN);

endmodule

// File: rtl/multi_ch_counter.sv
// multi_ch_counter
// NUM_CH independent counter channels sharing one count enable, with a
// masked interrupt output.
// Build option: define MULTI_CH_COUNTER_PRESCALE_EN to add the 8-bit
// prescale input and a shared prescaler issuing one tick per prescale+1
// clken cycles. Without it every clken cycle is a tick.
// Ports:
//   clk, sreset_n                 clock, synchronous active-low reset
//   clken                         global count enable
//   prescale                      (option only) tick divider minus one
//   start, stop, clear            per-channel control strobes
//   mode                          2 bits per channel
//   step, limit, clear_value      WIDTH bits per channel
//   count_value                   WIDTH bits per channel
//   running, tc_pulse             per-channel status
//   irq_mask, irq_clr, irq_status per-channel interrupt control/status
//   irq                           OR of masked irq_status
module multi_ch_counter
   import multi_ch_counter_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    sreset_n,
   input  logic                    clken,
`ifdef MULTI_CH_COUNTER_PRESCALE_EN
   input  logic [PRESCALE_W-1:0]   prescale,
`endif
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       clear,
   input  logic [2*NUM_CH-1:0]     mode,
   input  logic [NUM_CH*WIDTH-1:0] step,
   input  logic [NUM_CH*WIDTH-1:0] limit,
   input  logic [NUM_CH*WIDTH-1:0] clear_value,
   output logic [NUM_CH*WIDTH-1:0] count_value,
   output logic [NUM_CH-1:0]       running,
   output logic [NUM_CH-1:0]       tc_pulse,
   input  logic [NUM_CH-1:0]       irq_mask,
   input  logic [NUM_CH-1:0]       irq_clr,
   output logic [NUM_CH-1:0]       irq_status,
   output logic                    irq
);

   logic tick;

`ifdef MULTI_CH_COUNTER_PRESCALE_EN
   logic [PRESCALE_W-1:0] presc_cnt;

   // The >= compare lets the divider recover at once if prescale is
   // lowered below the current count.
   assign tick = clken && (presc_cnt >= prescale);

   // Prescaler advances only on clken cycles, restarting after each tick.
   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         presc_cnt <= '0;
      end else if (clken) begin
         presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      end
   end
`else
   assign tick = clken;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      counter_chan #(.WIDTH(WIDTH)) u_chan (
         .clk         (clk),
         .sreset_n    (sreset_n),
         .tick        (tick),
         .start       (start[c]),
         .stop        (stop[c]),
         .clear       (clear[c]),
         .mode        (mode[2*c +: 2]),
         .step        (step[c*WIDTH +: WIDTH]),
         .limit       (limit[c*WIDTH +: WIDTH]),
         .clear_value (clear_value[c*WIDTH +: WIDTH]),
         .irq_clr     (irq_clr[c]),
         .count_value (count_value[c*WIDTH +: WIDTH]),
         .running     (running[c]),
         .tc_pulse    (tc_pulse[c]),
         .irq_status  (irq_status[c])
      );
   end

   assign irq = |(irq_status & irq_mask);

endmodule

// File: tb/tb_multi_ch_counter.sv
// tb_multi_ch_counter
// Directed scenarios followed by randomized traffic for multi_ch_counter
// (NUM_CH=4, WIDTH=8), checked every cycle against a behavioural model.
// Honours MULTI_CH_COUNTER_PRESCALE_EN when the design is built with it.
module tb_multi_ch_counter;

   localparam int NCH = 4;
   localparam int W   = 8;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic             clk = 1'b0;
   logic             sreset_n = 1'b0;
   logic             clken = 1'b0;
   logic [7:0]       prescale = 8'd0;
   logic [NCH-1:0]   start = '0, stop = '0, clear = '0;
   logic [2*NCH-1:0] mode = '0;
   logic [NCH*W-1:0] step = '0, limit = '0, clear_value = '0;
   logic [NCH*W-1:0] count_value;
   logic [NCH-1:0]   running, tc_pulse, irq_status;
   logic [NCH-1:0]   irq_mask = '0, irq_clr = '0;
   logic             irq;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   int m_cnt [NCH];
   int m_st  [NCH];
   bit m_tc  [NCH];
   bit m_irq [NCH];
   int m_pcnt = 0;

   always #5 clk = ~clk;

   multi_ch_counter #(.NUM_CH(NCH), .WIDTH(W)) dut (
      .clk         (clk),
      .sreset_n    (sreset_n),
      .clken       (clken),
`ifdef MULTI_CH_COUNTER_PRESCALE_EN
      .prescale    (prescale),
`endif
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .mode        (mode),
      .step        (step),
      .limit       (limit),
      .clear_value (clear_value),
      .count_value (count_value),
      .running     (running),
      .tc_pulse    (tc_pulse),
      .irq_mask    (irq_mask),
      .irq_clr     (irq_clr),
      .irq_status  (irq_status),
      .irq         (irq)
   );

   task automatic checkEq(input string name, input logic [31:0] observed,
                          input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   task automatic setChannel(input int c, input int md, input int st,
                             input int lm, input int cv);
      mode[2*c +: 2]        = md[1:0];
      step[c*W +: W]        = st[7:0];
      limit[c*W +: W]       = lm[7:0];
      clear_value[c*W +: W] = cv[7:0];
   endtask

   function automatic int chCount(input int c);
      return int'(count_value[c*W +: W]);
   endfunction

   // Rules-level model of one clock edge using the inputs now applied.
   task automatic modelEdge();
      bit tick;
      int md, st, lm, cv;
`ifdef MULTI_CH_COUNTER_PRESCALE_EN
      tick = clken && (m_pcnt >= int'(prescale));
`else
      tick = clken;
`endif
      if (!sreset_n) m_pcnt = 0;
      else if (clken) m_pcnt = tick ? 0 : m_pcnt + 1;
      for (int c = 0; c < NCH; c++) begin
         md = int'(mode[2*c +: 2]);
         if (md == 3) md = 0;
         st = int'(step[c*W +: W]);
         lm = int'(limit[c*W +: W]);
         cv = int'(clear_value[c*W +: W]);
         if (!sreset_n) begin
            m_cnt[c] = 0; m_st[c] = M_IDLE; m_tc[c] = 0; m_irq[c] = 0;
         end else begin
            m_irq[c] = m_tc[c] | (m_irq[c] & !irq_clr[c]);
            m_tc[c]  = 0;
            if (clear[c]) begin
               m_cnt[c] = cv;
               if (m_st[c] == M_DONE) m_st[c] = M_IDLE;
            end else if (stop[c]) begin
               if (m_st[c] == M_RUN) m_st[c] = M_IDLE;
            end else if (start[c] && m_st[c] != M_RUN) begin
               if (m_st[c] == M_DONE) m_cnt[c] = cv;
               m_st[c] = M_RUN;
            end else if (m_st[c] == M_RUN && tick) begin
               if (m_cnt[c] == lm) begin
                  m_tc[c] = 1;
                  if (md == 1) m_st[c] = M_DONE;
                  else if (md == 2) begin m_cnt[c] = cv; m_st[c] = M_IDLE; end
                  else m_cnt[c] = cv;
               end else begin
                  m_cnt[c] = (m_cnt[c] + st) % 256;
               end
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [NCH-1:0] e_run, e_tc, e_irq;
      for (int c = 0; c < NCH; c++) begin
         checkEq($sformatf("%s count ch%0d", tag, c), 32'(chCount(c)), 32'(m_cnt[c]));
         e_run[c] = (m_st[c] == M_RUN);
         e_tc[c]  = m_tc[c];
         e_irq[c] = m_irq[c];
      end
      checkEq({tag, " running"}, 32'(running), 32'(e_run));
      checkEq({tag, " tc_pulse"}, 32'(tc_pulse), 32'(e_tc));
      checkEq({tag, " irq_status"}, 32'(irq_status), 32'(e_irq));
      checkEq({tag, " irq"}, 32'(irq), 32'(|(e_irq & irq_mask)));
   endtask

   // One clock: model the edge, wait past it, check, drop the strobes.
   task automatic applyStimulus(input string tag);
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput(tag);
      start = '0; stop = '0; clear = '0; irq_clr = '0;
   endtask

   initial begin
      int pulses, last, seen;
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_st[c] = M_IDLE; m_tc[c] = 0; m_irq[c] = 0;
      end
      @(negedge clk);

      // Reset, with strobes asserted to show reset overrides them.
      sreset_n = 1'b0; clken = 1'b1; start = '1;
      applyStimulus("reset");
      applyStimulus("reset");
      checkEq("reset count_value", 32'(count_value), 32'd0);
      checkEq("reset running", 32'(running), 32'd0);
      sreset_n = 1'b1;

      // Wrap: 0,1..5,0 with tc_pulse alongside the reloaded 0.
      setChannel(0, 0, 1, 5, 0);
      clear[0] = 1'b1; applyStimulus("wrap clear");
      start[0] = 1'b1; applyStimulus("wrap start");
      pulses = 0; last = 0;
      for (int i = 1; i <= 14; i++) begin
         applyStimulus("wrap run");
         if (tc_pulse[0]) begin
            checkEq("wrap tc count", 32'(chCount(0)), 32'd0);
            if (pulses > 0) checkEq("wrap period", 32'(i - last), 32'd6);
            pulses++; last = i;
         end
      end
      checkEq("wrap pulses", 32'(pulses), 32'd2);

      // Saturate down from 10 to 3, one pulse, then DONE.
      setChannel(1, 1, 8'hFF, 3, 10);
      clear[1] = 1'b1; applyStimulus("sat clear");
      checkEq("sat clear value", 32'(chCount(1)), 32'd10);
      start[1] = 1'b1; applyStimulus("sat start");
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus("sat run");
         if (tc_pulse[1]) pulses++;
      end
      checkEq("sat pulses", 32'(pulses), 32'd1);
      checkEq("sat hold", 32'(chCount(1)), 32'd3);
      checkEq("sat running", 32'(running[1]), 32'd0);

      // One-shot 0,2,4,0 then IDLE; start counts again from 0.
      setChannel(2, 2, 2, 4, 0);
      clear[2] = 1'b1; applyStimulus("oneshot clear");
      start[2] = 1'b1; applyStimulus("oneshot start");
      for (int i = 0; i < 5; i++) applyStimulus("oneshot run");
      checkEq("oneshot idle", 32'(running[2]), 32'd0);
      checkEq("oneshot reload", 32'(chCount(2)), 32'd0);
      start[2] = 1'b1; applyStimulus("oneshot restart");
      applyStimulus("oneshot restart run");
      checkEq("oneshot recount", 32'(chCount(2)), 32'd2);

      // IRQ race: clear in the same cycle as tc_pulse[0], set wins.
      irq_mask = 4'b0001;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         applyStimulus("irq wait");
         if (m_tc[0]) seen = 1;
      end
      checkEq("irq tc seen", 32'(seen), 32'd1);
      irq_clr[0] = 1'b1; applyStimulus("irq race");
      checkEq("irq race status", 32'(irq_status[0]), 32'd1);
      checkEq("irq race irq", 32'(irq), 32'd1);
      irq_clr[0] = 1'b1; applyStimulus("irq clear");
      checkEq("irq clear status", 32'(irq_status[0]), 32'd0);
      checkEq("irq clear irq", 32'(irq), 32'd0);

      // Reset mid-run at ch0 count 3.
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         applyStimulus("rst wait");
         if (m_cnt[0] == 3 && m_st[0] == M_RUN) seen = 1;
      end
      checkEq("rst count3 seen", 32'(seen), 32'd1);
      sreset_n = 1'b0; applyStimulus("rst mid");
      checkEq("rst mid count", 32'(chCount(0)), 32'd0);
      checkEq("rst mid running", 32'(running), 32'd0);
      checkEq("rst mid irq_status", 32'(irq_status), 32'd0);
      sreset_n = 1'b1; applyStimulus("rst after");
      checkEq("rst after tc", 32'(tc_pulse), 32'd0);
      checkEq("rst after irq", 32'(irq), 32'd0);

`ifdef MULTI_CH_COUNTER_PRESCALE_EN
      // Prescale 2: one count per three clken cycles, idle cycles ignored.
      prescale = 8'd2; clken = 1'b0;
      sreset_n = 1'b0; applyStimulus("presc reset");
      sreset_n = 1'b1;
      setChannel(3, 0, 1, 200, 0);
      clear[3] = 1'b1; applyStimulus("presc clear");
      start[3] = 1'b1; applyStimulus("presc start");
      for (int i = 0; i < 9; i++) begin
         clken = 1'b1; applyStimulus("presc on");
         clken = 1'b0; applyStimulus("presc off");
      end
      checkEq("presc count", 32'(chCount(3)), 32'd3);
      clken = 1'b1;
`endif

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) begin
            for (int c = 0; c < NCH; c++) begin
               int r, s;
               r = $urandom_range(0, 3);
               s = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 255 : $urandom_range(0, 255);
               setChannel(c, $urandom_range(0, 3), s, $urandom_range(0, 15),
                          $urandom_range(0, 7));
            end
            irq_mask = 4'($urandom_range(0, 15));
            prescale = 8'($urandom_range(0, 3));
         end
         clken    = ($urandom_range(0, 3) != 0);
         sreset_n = ($urandom_range(0, 99) != 0);
         for (int c = 0; c < NCH; c++) begin
            start[c]   = ($urandom_range(0, 7) == 0);
            stop[c]    = ($urandom_range(0, 31) == 0);
            clear[c]   = ($urandom_range(0, 31) == 0);
            irq_clr[c] = ($urandom_range(0, 3) == 0);
         end
         applyStimulus("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_ch_counter.md
MULTI_CH_COUNTER -- requirements
Module: multi_ch_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 16: counter width per channel (2..32).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port sreset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clken  input  1  global count enable; counting occurs only on clk edges with clken=1.
REQ-006 SHALL have port start  input  NUM_CH  per-channel start request.
REQ-007 SHALL have port stop  input  NUM_CH  per-channel stop request.
REQ-008 SHALL have port clear  input  NUM_CH  per-channel load of clear_value.
REQ-009 SHALL have port mode  input  2*NUM_CH  per channel: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-010 SHALL have ports step, limit, clear_value  input  NUM_CH*WIDTH  per-channel increment (two's complement), terminal value, reload value.
REQ-011 SHALL have port count_value  output  NUM_CH*WIDTH  per-channel counter.
REQ-012 SHALL have ports running / tc_pulse  output  NUM_CH  channel in RUN / one-cycle terminal-count pulse.
REQ-013 SHALL have ports irq_mask, irq_clr  input  NUM_CH; irq_status  output  NUM_CH sticky; irq  output  1.

Function
REQ-014 Each channel SHALL have states IDLE, RUN, DONE; running=1 only in RUN.
REQ-015 start, stop and clear SHALL act on every clk edge regardless of clken; priority: clear > stop > start > count.
REQ-016 clear SHALL load clear_value; DONE->IDLE; IDLE and RUN unchanged.
REQ-017 stop SHALL move RUN->IDLE, holding count_value.
REQ-018 start SHALL move IDLE->RUN holding count; DONE->RUN loading clear_value; no effect in RUN.
REQ-019 Tick = RUN & clken (& prescaler tick, REQ-028); on tick, count!=limit: count <= (count+step) mod 2^WIDTH.
REQ-020 On tick with count==limit: wrap loads clear_value, stays RUN; saturate holds count, goes DONE; one-shot loads clear_value, goes IDLE.
REQ-021 A limit skipped by step SHALL NOT generate a terminal event; count wraps modulo 2^WIDTH.
REQ-022 tc_pulse SHALL be registered, high exactly one cycle after the terminal tick, coincident with the updated count_value.
REQ-023 irq_status bit SHALL set when tc_pulse is high and clear on irq_clr; simultaneous set and clear: set wins.
REQ-024 irq SHALL equal the OR of (irq_status & irq_mask), combinational from registers.

Reset
REQ-025 While sreset_n=0 at a clk edge: every count_value 0, state IDLE, running 0, tc_pulse 0, irq_status 0, irq 0, prescaler 0.
REQ-026 Reset SHALL override all other inputs, including mid-count; no terminal event or irq generated by reset.

Configuration
REQ-027 Macro MULTI_CH_COUNTER_PRESCALE_EN SHALL, when defined, add input prescale (8 bits) and a shared prescaler counter.
REQ-028 With it, prescaler SHALL count clken cycles 0..prescale, issuing one tick per prescale+1 clken cycles; prescale=0 gives a tick every clken cycle.
REQ-029 Without it, port prescale and prescaler logic SHALL be absent and tick = clken.

Structure
REQ-030 Package multi_ch_counter_pkg SHALL hold mode encodings, state encodings and parameter bounds.
REQ-031 Sub-module counter_chan SHALL implement one channel (REQ-014..023), instantiated NUM_CH times by generate; top holds prescaler and irq OR.

Verification (WIDTH=8, NUM_CH=4)
REQ-032 Wrap: ch0 clear_value=0, step=1, limit=5, start, clken=1 -> count 0,1..5,0; tc_pulse with count 0, period 6 cycles.
REQ-033 Saturate down: ch1 clear_value=10, step=8'hFF, limit=3, clear then start -> count 10..3, holds 3, one tc_pulse, running=0, state DONE.
REQ-034 One-shot plus restart: ch2 clear_value=0, step=2, limit=4 -> 0,2,4,0 then IDLE; start -> counts again from 0.
REQ-035 IRQ race: irq_mask=4'b0001, irq_clr[0]=1 in same cycle as tc_pulse[0] -> irq_status[0]=1, irq=1; later irq_clr alone -> 0.
REQ-036 Reset mid-run: sreset_n=0 at ch0 count 3 -> next cycle count 0, running 0, irq_status 0, no tc_pulse.
REQ-037 With MULTI_CH_COUNTER_PRESCALE_EN, prescale=2, step=1 -> count increments once per 3 clken cycles; clken=0 cycles not counted.
